// File: rtl/pcm_uart_tx_pkg.sv
// pcm_uart_tx_pkg: shared definitions for the PCM <-> UART frame paths.
//   state_e        : transmit sequencer states
//   BYTEn_LSB      : bit position of wire byte n inside a {L[15:0], R[15:0]} word
//   frame_byte()   : picks wire byte idx out of a 32-bit frame
// The playback receiver uses the same byte-order constants, so both
// directions share one wire format.
package pcm_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_CTS,
    ST_SEND,
    ST_ARM,
    ST_DRAIN
  } state_e;

  localparam int FRAME_BYTES = 4;

  // Little-endian per channel, left channel first.
  localparam int BYTE0_LSB = 16;  // L low
  localparam int BYTE1_LSB = 24;  // L high
  localparam int BYTE2_LSB = 0;   // R low
  localparam int BYTE3_LSB = 8;   // R high

  function automatic logic [7:0] frame_byte(input logic [31:0] frame,
                                            input logic [1:0]  idx);
    logic [7:0] b;
    b = frame[BYTE0_LSB +: 8];
    case (idx)
      2'd0: b = frame[BYTE0_LSB +: 8];
      2'd1: b = frame[BYTE1_LSB +: 8];
      2'd2: b = frame[BYTE2_LSB +: 8];
      2'd3: b = frame[BYTE3_LSB +: 8];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pcm_uart_tx_sync_ff.sv
// sync_ff: STAGES-deep single-bit synchronizer for asynchronous pins.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset (all stages clear to 0)
//   d_i    : asynchronous input
//   q_o    : synchronized output, STAGES cycles of latency
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pcm_uart_tx.sv
// pcm_uart_tx: serializes stereo 16-bit PCM words into four UART bytes.
//   clk, reset_n        : system clock, asynchronous active-low reset
//   in_data/valid/ready : one {L,R} word per handshake (ready only in IDLE)
//   host_cts            : asynchronous host flow control, sampled at frame start
//   tx_data, tx_start   : byte and one-cycle start pulse to the UART transmitter
//   tx_busy             : transmitter shifting
//   active              : frame in progress
//   frames_sent         : completed-frame counter, wraps silently
module pcm_uart_tx
  import pcm_uart_tx_pkg::*;
#(
  parameter int CTS_SYNC   = 2,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  host_cts,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  active,
  output logic [COUNT_BITS-1:0] frames_sent
);

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           frame_q, frame_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  active_q, active_d;
  logic [COUNT_BITS-1:0] frames_q, frames_d;
  logic                  run_q;
  logic                  cts_sync;

  sync_ff #(.STAGES(CTS_SYNC)) u_cts_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (host_cts),
    .q_o    (cts_sync)
  );

  // run_q keeps in_ready low while reset is held even though the state
  // register already sits in IDLE.
  assign in_ready = run_q && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    tx_data_d = tx_data_q;
    frames_d  = frames_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          frame_d = in_data;
          state_d = ST_WAIT_CTS;
        end
      end
      // CTS only gates frame start; once committed the frame always completes.
      ST_WAIT_CTS: begin
        if (cts_sync && !tx_busy) begin
          idx_d     = 2'd0;
          tx_data_d = frame_byte(frame_q, 2'd0);
          state_d   = ST_SEND;
        end
      end
      ST_SEND: state_d = ST_ARM;
      // Transmitter busy lags start by a cycle; skip one before watching it.
      ST_ARM:  state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!tx_busy) begin
          if (idx_q == 2'd3) begin
            frames_d = frames_q + COUNT_BITS'(1);
            state_d  = ST_IDLE;
          end else begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = frame_byte(frame_q, idx_q + 2'd1);
            state_d   = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered against the next state so they line up with it.
    tx_start_d = (state_d == ST_SEND);
    active_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      frame_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      active_q   <= 1'b0;
      frames_q   <= '0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      active_q   <= active_d;
      frames_q   <= frames_d;
      run_q      <= 1'b1;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign active      = active_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_pcm_uart_tx.sv
module tb_pcm_uart_tx;

  localparam int CTS_SYNC   = 2;
  localparam int COUNT_BITS = 16;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [31:0]           in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  host_cts;
  logic [7:0]            tx_data;
  logic                  tx_start;
  logic                  tx_busy;
  logic                  active;
  logic [COUNT_BITS-1:0] frames_sent;

  pcm_uart_tx #(.CTS_SYNC(CTS_SYNC), .COUNT_BITS(COUNT_BITS)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .host_cts    (host_cts),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .active      (active),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_len = 0;
  int busy_cnt = 0;
  int width_err = 0;
  int ready_err = 0;
  logic prev_start = 1'b0;
  logic [7:0] byte_q[$];
  int exp_frames;

  // UART transmitter model plus host-side byte capture.
  always @(negedge clk) begin
    if (tx_start) begin
      byte_q.push_back(tx_data);
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end
    tx_busy = (busy_cnt != 0);
    if (tx_start && prev_start) width_err++;
    if (in_ready && active) ready_err++;
    prev_start = tx_start;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wire_order(input logic [31:0] w);
    return {w[23:16], w[31:24], w[7:0], w[15:8]};
  endfunction

  task automatic pop4(output logic [31:0] b);
    b = 32'hxxxx_xxxx;
    if (byte_q.size() >= 4) begin
      b = {byte_q[0], byte_q[1], byte_q[2], byte_q[3]};
      repeat (4) void'(byte_q.pop_front());
    end
  endtask

  task automatic send_word(input logic [31:0] d);
    int cnt;
    in_valid = 1'b1;
    in_data  = d;
    cnt = 0;
    while (!in_ready && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 1000) check("accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while (active && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 2000) check("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] data;
    logic [31:0] exp_bytes;
  } vec_t;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    logic [31:0] got;
    int cnt;

    vecs[0] = '{32'h1234_ABCD, 32'h3412_CDAB};
    vecs[1] = '{32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3] = '{32'hA55A_0FF0, 32'h5AA5_F00F};
    vecs[4] = '{32'h8001_0100, 32'h0180_0001};

    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; host_cts = 1'b1; tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Table: byte order and frame count
    busy_len = 5;
    exp_frames = 0;
    for (int i = 0; i < 5; i++) begin
      send_word(vecs[i].data);
      wait_idle();
      pop4(got);
      exp_frames++;
      check($sformatf("vec%0d_bytes", i), got, vecs[i].exp_bytes);
      check($sformatf("vec%0d_frames", i), 32'(frames_sent), 32'(exp_frames));
    end

    // Accept-to-first-start latency
    busy_len = 0;
    in_valid = 1'b1; in_data = 32'hCAFE_BABE;
    cnt = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      cnt++;
    end while (!tx_start && cnt < 20);
    check("accept_latency", 32'(cnt), 32'd2);
    wait_idle();
    pop4(got);
    exp_frames++;
    check("latency_bytes", got, 32'hFECA_BEBA);

    // CTS held low, then raised
    busy_len = 3;
    host_cts = 1'b0;
    repeat (4) @(negedge clk);
    send_word(32'h5555_AAAA);
    repeat (10) @(negedge clk);
    check("cts0_no_bytes", 32'(byte_q.size()), 32'd0);
    check("cts0_active", 32'(active), 32'd1);
    check("cts0_in_ready", 32'(in_ready), 32'd0);
    host_cts = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!tx_start && cnt < 20);
    check("cts_latency", 32'(cnt), 32'(CTS_SYNC + 1));
    wait_idle();
    pop4(got);
    exp_frames++;
    check("cts0_bytes", got, 32'h5555_AAAA);

    // CTS drop after byte1: frame completes, next frame stalls
    busy_len = 10;
    send_word(32'h0BAD_F00D);
    cnt = 0;
    while (byte_q.size() < 2 && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    host_cts = 1'b0;
    wait_idle();
    pop4(got);
    exp_frames++;
    check("ctsdrop_bytes", got, 32'hAD0B_0DF0);
    send_word(32'h1122_3344);
    repeat (20) @(negedge clk);
    check("ctsdrop_stall_active", 32'(active), 32'd1);
    check("ctsdrop_stall_bytes", 32'(byte_q.size()), 32'd0);
    host_cts = 1'b1;
    wait_idle();
    pop4(got);
    exp_frames++;
    check("ctsdrop_next_bytes", got, 32'h2211_4433);
    check("ctsdrop_frames", 32'(frames_sent), 32'(exp_frames));

    // Asynchronous reset while byte2 start pulse is high
    busy_len = 40;
    send_word(32'h1234_ABCD);
    cnt = 0;
    while (!(tx_start && tx_data == 8'hCD) && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("byte2_seen", 32'(tx_start), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_tx_start", 32'(tx_start), 32'd0);
    check("arst_active", 32'(active), 32'd0);
    check("arst_tx_data", 32'(tx_data), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_frames", 32'(frames_sent), 32'd0);
    busy_cnt = 0;
    tx_busy = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    byte_q.delete();
    repeat (CTS_SYNC + 2) @(negedge clk);
    send_word(32'hCAFE_F00D);
    wait_idle();
    check("post_rst_count", 32'(byte_q.size()), 32'd4);
    pop4(got);
    exp_frames = 1;
    check("post_rst_bytes", got, 32'hFECA_0DF0);

    // 100 frames with continuous in_valid, 40-cycle busy
    byte_q.delete();
    in_valid = 1'b1;
    for (int f = 0; f < 100; f++) begin
      in_data = {16'(f * 257 + 4951), 16'(16'hFEDC - f * 515)};
      cnt = 0;
      while (!in_ready && cnt < 1000) begin
        @(negedge clk);
        cnt++;
      end
      if (cnt >= 1000) check("stream_accept_timeout", 32'd1, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_idle();
    exp_frames += 100;
    check("stream_byte_count", 32'(byte_q.size()), 32'd400);
    for (int f = 0; f < 100; f++) begin
      pop4(got);
      check($sformatf("stream_f%0d", f), got,
            wire_order({16'(f * 257 + 4951), 16'(16'hFEDC - f * 515)}));
    end
    check("stream_frames", 32'(frames_sent), 32'(exp_frames));

    // Counter wrap
    busy_len = 2;
    force dut.frames_q = 16'hFFFF;
    @(negedge clk);
    release dut.frames_q;
    send_word(32'h0102_0304);
    wait_idle();
    pop4(got);
    check("wrap_bytes", got, 32'h0201_0403);
    check("wrap_frames", 32'(frames_sent), 32'd0);

    check("start_pulse_width", 32'(width_err), 32'd0);
    check("in_ready_in_frame", 32'(ready_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
